shift_sequencer: RTL and testbench
==================================

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 Parameter: WIDTH, 32, data width of the operand and result.
REQ-002 Parameter: CONST_AMT, 16, fixed shift amount used when amt_sel=01.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request to begin a shift operation; sampled only in IDLE.
REQ-006 abort  input  1  synchronous cancel of an operation in progress.
REQ-007 op  input  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
REQ-008 amt_sel  input  2  amount source: 00 shamt_in, 01 CONST_AMT, 10 rs_in, 11 mem_in.
REQ-009 operand  input  WIDTH  value to be shifted.
REQ-010 shamt_in, rs_in, mem_in  input  WIDTH each  amount sources; only bits [4:0] are used.
REQ-011 busy  output  1  high in LOAD-free states SHIFT and DONE.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 result  output  WIDTH  shifted value; held stable outside SHIFT.

Function
REQ-014 FSM states SHALL be IDLE, SHIFT and DONE.
REQ-015 In IDLE with start=1 at a rising edge, the block SHALL capture operand, op, and the 5-bit amount selected by amt_sel (CONST_AMT[4:0] for 01).
REQ-016 A captured amount of 0 SHALL go IDLE->DONE with result=operand.
REQ-017 A nonzero amount SHALL go IDLE->SHIFT and load the counter with the amount.
REQ-018 In SHIFT, each edge SHALL shift result by exactly one bit per op and decrement the counter.
REQ-019 SLL fills with 0 at bit 0; SRL fills with 0 at the MSB; SRA replicates the MSB; ROR moves bit 0 into the MSB.
REQ-020 When the counter is 1 at an edge in SHIFT, that edge SHALL perform the final shift and move to DONE.
REQ-021 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-022 Latency: done SHALL be high in the cycle N+1 after the start cycle, where N is the amount (0..31).
REQ-023 start SHALL be ignored while busy=1; start in the DONE cycle is ignored.
REQ-024 Inputs other than start/abort SHALL NOT affect an operation after capture.
REQ-025 abort=1 in SHIFT SHALL return to IDLE on that edge with no done pulse and result holding its partially shifted value.
REQ-026 If abort and start are both high in IDLE, abort has priority and start is ignored.
REQ-027 abort in DONE SHALL have no effect.
REQ-028 result SHALL retain its last value in IDLE until the next capture.

Reset
REQ-029 reset_n=0 SHALL immediately force state=IDLE, counter=0, result=0, busy=0, done=0, independent of clk.
REQ-030 Reset asserted mid-SHIFT SHALL discard the operation; no done pulse follows deassertion.
REQ-031 After reset deassertion, the first start SHALL be honoured on the next rising edge.

Structure
REQ-032 A shared package shift_seq_pkg SHALL hold the op encodings, amt_sel encodings, state enumeration and the 5-bit amount width constant.
REQ-033 One combinational sub-module, shift_step, SHALL compute the one-bit shift of a WIDTH value for a given op.
REQ-034 The amount mux and FSM SHALL reside in shift_sequencer.

Verification
REQ-035 Run SLL with operand=0x0000_0001, amt_sel=01: done is high 17 cycles after start, and result=0x0001_0000.
REQ-036 Run SRA with operand=0x8000_0000 and shamt_in=4: result=0xF800_0000, and done is high in start+5.
REQ-037 Run ROR with operand=0x0000_0003 and rs_in=0x0000_0021 (amount 1): result=0x8000_0001.
REQ-038 Run with an amount of 0 from mem_in=0x20: done is high in start+1, result=operand, and busy is high for 1 cycle.
REQ-039 Assert start during SHIFT with different operand/op: the first operation completes unchanged, and the second start is not honoured.
REQ-040 For a SRL of 8, issue abort after 3 shifts and then reset mid-operation: there is no done pulse, result=operand>>3 after the abort, and all outputs are 0 immediately on reset_n=0.

Source files
------------

// File: rtl/shift_seq_pkg.sv
// Shared definitions for the shift sequencer: operation and amount-source
// encodings, FSM state enumeration and the width of the shift amount.
package shift_seq_pkg;

    // Only the low 5 bits of any amount source are significant.
    localparam int unsigned AMT_W = 5;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        AMT_SHAMT = 2'b00,
        AMT_CONST = 2'b01,
        AMT_RS    = 2'b10,
        AMT_MEM   = 2'b11
    } amt_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational single-bit shift of a WIDTH-bit value.
//   din  : value to shift
//   op   : 00 SLL, 01 SRL, 10 SRA, 11 ROR
//   dout : din shifted/rotated by exactly one bit position
module shift_step
    import shift_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] din,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] dout
);

    always_comb begin
        dout = din;
        case (op_e'(op))
            OP_SLL:  dout = {din[WIDTH-2:0], 1'b0};
            OP_SRL:  dout = {1'b0, din[WIDTH-1:1]};
            OP_SRA:  dout = {din[WIDTH-1], din[WIDTH-1:1]};
            OP_ROR:  dout = {din[0], din[WIDTH-1:1]};
            default: dout = din;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shifter: captures an operand, operation and 5-bit amount on
// start, then shifts one bit per clock until the amount is exhausted.
//   clk, reset_n          : clock, asynchronous active-low reset
//   start, abort          : begin request (IDLE only) / cancel in SHIFT
//   op, amt_sel           : operation and amount source select
//   operand               : value to shift
//   shamt_in, rs_in, mem_in : amount sources, bits [4:0] used
//   busy, done, result    : SHIFT/DONE indicator, one-cycle completion
//                           pulse, shifted value (held outside SHIFT)
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned CONST_AMT = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic [1:0]       op,
    input  logic [1:0]       amt_sel,
    input  logic [WIDTH-1:0] operand,
    input  logic [WIDTH-1:0] shamt_in,
    input  logic [WIDTH-1:0] rs_in,
    input  logic [WIDTH-1:0] mem_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam logic [AMT_W-1:0] CONST_AMT5 = AMT_W'(CONST_AMT);

    state_e           state, state_nxt;
    logic [AMT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       op_q, op_nxt;
    logic [WIDTH-1:0] result_nxt;
    logic [WIDTH-1:0] step_out;
    logic [AMT_W-1:0] amt;

    // Upper bits of the amount sources are architecturally ignored.
    logic unused_amt_bits;
    assign unused_amt_bits = ^{shamt_in[WIDTH-1:AMT_W], rs_in[WIDTH-1:AMT_W],
                               mem_in[WIDTH-1:AMT_W]};

    always_comb begin
        amt = shamt_in[AMT_W-1:0];
        case (amt_sel_e'(amt_sel))
            AMT_SHAMT: amt = shamt_in[AMT_W-1:0];
            AMT_CONST: amt = CONST_AMT5;
            AMT_RS:    amt = rs_in[AMT_W-1:0];
            AMT_MEM:   amt = mem_in[AMT_W-1:0];
            default:   amt = shamt_in[AMT_W-1:0];
        endcase
    end

    shift_step #(.WIDTH(WIDTH)) u_step (
        .din  (result),
        .op   (op_q),
        .dout (step_out)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            op_q   <= '0;
            result <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            op_q   <= op_nxt;
            result <= result_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        op_nxt     = op_q;
        result_nxt = result;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                // abort outranks a simultaneous start
                if (start && !abort) begin
                    op_nxt     = op;
                    result_nxt = operand;
                    cnt_nxt    = amt;
                    state_nxt  = (amt == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                busy = 1'b1;
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else begin
                    result_nxt = step_out;
                    cnt_nxt    = cnt - AMT_W'(1);
                    if (cnt == AMT_W'(1))
                        state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;
    import shift_seq_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        abort;
    logic [1:0]  op;
    logic [1:0]  amt_sel;
    logic [31:0] operand;
    logic [31:0] shamt_in;
    logic [31:0] rs_in;
    logic [31:0] mem_in;
    logic        busy;
    logic        done;
    logic [31:0] result;

    shift_sequencer #(.WIDTH(32), .CONST_AMT(16)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .abort    (abort),
        .op       (op),
        .amt_sel  (amt_sel),
        .operand  (operand),
        .shamt_in (shamt_in),
        .rs_in    (rs_in),
        .mem_in   (mem_in),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    typedef struct {
        logic [31:0] res;
        int          cyc;
        string       name;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: every done cycle must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset_n && done) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d, expected none", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                check({e.name, "_result"}, result, e.res);
                check({e.name, "_latency"}, 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Called at a negedge. Starts an op, then scrambles all non-control inputs.
    task automatic issue(input string name, input logic [1:0] o, input logic [1:0] s,
                         input logic [31:0] opd, input logic [31:0] src,
                         input logic [31:0] exp_res, input int n, input bit push);
        exp_t e;
        op       = o;
        amt_sel  = s;
        operand  = opd;
        shamt_in = $urandom;
        rs_in    = $urandom;
        mem_in   = $urandom;
        case (s)
            2'b00:   shamt_in = src;
            2'b10:   rs_in    = src;
            2'b11:   mem_in   = src;
            default: ;
        endcase
        start = 1'b1;
        if (push) begin
            e.res  = exp_res;
            e.cyc  = cyc + 1 + n;
            e.name = name;
            q.push_back(e);
        end
        @(negedge clk);
        start    = 1'b0;
        op       = 2'($urandom);
        amt_sel  = 2'($urandom);
        operand  = $urandom;
        shamt_in = $urandom;
        rs_in    = $urandom;
        mem_in   = $urandom;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: got %0d pending, expected 0", name, q.size());
            q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int bcnt;
        logic [31:0] held;

        reset_n  = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        op       = '0;
        amt_sel  = '0;
        operand  = '0;
        shamt_in = '0;
        rs_in    = '0;
        mem_in   = '0;
        repeat (2) @(negedge clk);
        check("reset_busy",   32'(busy), 32'd0);
        check("reset_done",   32'(done), 32'd0);
        check("reset_result", result,    32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // SLL by CONST_AMT (16)
        issue("sll_const", 2'b00, 2'b01, 32'h0000_0001, 32'h0, 32'h0001_0000, 16, 1'b1);
        drain("sll_const");

        // SRA by shamt_in=4
        issue("sra_4", 2'b10, 2'b00, 32'h8000_0000, 32'd4, 32'hF800_0000, 4, 1'b1);
        drain("sra_4");

        // ROR by rs_in=0x21 (amount 1); abort raised in the DONE cycle
        issue("ror_1", 2'b11, 2'b10, 32'h0000_0003, 32'h0000_0021, 32'h8000_0001, 1, 1'b1);
        @(negedge clk);
        check("ror_1_done_cycle", 32'(done), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        drain("ror_1");

        // Amount 0 from mem_in=0x20: busy exactly one cycle
        issue("zero_amt", 2'b01, 2'b11, 32'hDEAD_BEEF, 32'h0000_0020, 32'hDEAD_BEEF, 0, 1'b1);
        bcnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (busy) bcnt++;
            @(negedge clk);
        end
        check("zero_amt_busy_cycles", 32'(bcnt), 32'd1);
        drain("zero_amt");

        // SLL by 5, with start attempts in SHIFT and in DONE
        issue("sll_5", 2'b00, 2'b00, 32'h0000_1234, 32'd5, 32'h0002_4680, 5, 1'b1);
        @(negedge clk);
        op = 2'b11; amt_sel = 2'b00; shamt_in = 32'd1; operand = 32'hFFFF_0000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("sll_5_done_seen", 32'(done), 32'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_in_done_ignored", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        check("sll_5_result_held", result, 32'h0002_4680);
        drain("sll_5");

        // SRL by 31 (maximum amount)
        issue("srl_31", 2'b01, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0001, 31, 1'b1);
        drain("srl_31");

        // abort together with start in IDLE: no capture
        held = result;
        op = 2'b00; amt_sel = 2'b00; shamt_in = 32'd3; operand = 32'h5555_5555;
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("abort_start_busy", 32'(busy), 32'd0);
        check("abort_start_result", result, held);

        // SRL by 8, abort after 3 shifts
        issue("srl_abort", 2'b01, 2'b00, 32'hF0F0_F0F0, 32'd8, 32'h0, 8, 1'b0);
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy",   32'(busy), 32'd0);
        check("abort_result", result,    32'h1E1E_1E1E);
        repeat (12) @(negedge clk);
        check("abort_result_held", result, 32'h1E1E_1E1E);

        // SRL by 8, reset mid-operation
        issue("srl_reset", 2'b01, 2'b00, 32'h0F0F_0F0F, 32'd8, 32'h0, 8, 1'b0);
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("midreset_busy",   32'(busy), 32'd0);
        check("midreset_done",   32'(done), 32'd0);
        check("midreset_result", result,    32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // First start right after reset release is honoured
        issue("post_reset", 2'b00, 2'b00, 32'h0000_0003, 32'd2, 32'h0000_000C, 2, 1'b1);
        drain("post_reset");
        repeat (12) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no completion, expected finish");
        $fatal(1, "timeout");
    end

endmodule
